// File: rtl/atan_pkg.sv
// rtl/atan_pkg.sv - shared widths, FSM encoding and octant bit positions for the atan pipeline
package atan_pkg;

    localparam int ATAN_IN_W   = 16;
    localparam int ATAN_FRAC_W = 8;

    // Octant bit positions, shared with the angle-reconstruction stage
    localparam int OCT_XNEG = 2;
    localparam int OCT_YNEG = 1;
    localparam int OCT_SWAP = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_DIV,
        ST_DONE
    } atan_state_t;

endpackage

// File: rtl/atan_restoring_div.sv
// rtl/atan_restoring_div.sv - restoring fractional divider, one quotient bit per cycle, MSB first
module atan_restoring_div #(
    parameter int DEN_W = 17,
    parameter int Q_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DEN_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             last,
    output logic [Q_W-1:0]   q
);

    localparam int CNT_W = $clog2(Q_W + 1);

    // num <= den always holds, so rem never exceeds den and one extra bit covers rem<<1
    logic [DEN_W:0]   rem;
    logic [DEN_W:0]   rem_sh;
    logic [DEN_W-1:0] den_r;
    logic [CNT_W-1:0] cnt;

    assign rem_sh = {rem[DEN_W-1:0], 1'b0};
    assign last   = (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem   <= '0;
            den_r <= '0;
            q     <= '0;
            cnt   <= '0;
        end else if (load) begin
            rem   <= {1'b0, num};
            den_r <= den;
            q     <= '0;
            cnt   <= CNT_W'(Q_W);
        end else if (cnt != '0) begin
            if (rem_sh >= {1'b0, den_r}) begin
                rem <= rem_sh - {1'b0, den_r};
                q   <= {q[Q_W-2:0], 1'b1};
            end else begin
                rem <= rem_sh;
                q   <= {q[Q_W-2:0], 1'b0};
            end
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/atan_ratio_prep.sv
// rtl/atan_ratio_prep.sv - folds (x,y) into the first octant and emits min/max as Q0.FRAC_W; ATAN_RATIO_ROUND_EN adds round-half-up
module atan_ratio_prep
    import atan_pkg::*;
#(
    parameter int IN_W   = ATAN_IN_W,
    parameter int FRAC_W = ATAN_FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              val_i,
    output logic              rdy_o,
    input  logic [IN_W-1:0]   x_i,
    input  logic [IN_W-1:0]   y_i,
    output logic              val_o,
    output logic [FRAC_W-1:0] ratio_o,
    output logic [2:0]        octant_o
);

    localparam int MAG_W = IN_W + 1;
`ifdef ATAN_RATIO_ROUND_EN
    localparam int Q_W = FRAC_W + 1;
`else
    localparam int Q_W = FRAC_W;
`endif

    atan_state_t       state, state_nxt;
    logic [MAG_W-1:0]  ax, ay, ax_in, ay_in;
    logic              x_neg, y_neg, swap, zero_f, swap_c;
    logic              accept, div_load, div_last;
    logic [Q_W-1:0]    q;
    logic [FRAC_W-1:0] ratio_nxt;
    logic [2:0]        oct_nxt;

    // One extra magnitude bit keeps abs(-2^(IN_W-1)) exact
    assign ax_in = x_i[IN_W-1] ? MAG_W'(0) - {1'b1, x_i} : {1'b0, x_i};
    assign ay_in = y_i[IN_W-1] ? MAG_W'(0) - {1'b1, y_i} : {1'b0, y_i};

    assign swap_c   = (ay > ax);
    assign rdy_o    = (state == ST_IDLE) || (state == ST_DONE);
    assign accept   = rdy_o && val_i;
    assign div_load = (state == ST_PREP);

    atan_restoring_div #(
        .DEN_W (MAG_W),
        .Q_W   (Q_W)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .load (div_load),
        .num  (swap_c ? ax : ay),
        .den  (swap_c ? ay : ax),
        .last (div_last),
        .q    (q)
    );

`ifdef ATAN_RATIO_ROUND_EN
    logic [FRAC_W:0] rnd_sum;
    assign rnd_sum   = {1'b0, q[Q_W-1:1]} + {{FRAC_W{1'b0}}, q[0]};
    assign ratio_nxt = zero_f ? '0 : (rnd_sum[FRAC_W] ? '1 : rnd_sum[FRAC_W-1:0]);
`else
    assign ratio_nxt = zero_f ? '0 : q;
`endif

    always_comb begin
        state_nxt = state;
        oct_nxt   = '0;
        oct_nxt[OCT_XNEG] = x_neg;
        oct_nxt[OCT_YNEG] = y_neg;
        oct_nxt[OCT_SWAP] = swap;
        case (state)
            ST_IDLE: if (val_i) state_nxt = ST_PREP;
            ST_PREP: state_nxt = ST_DIV;
            ST_DIV:  if (div_last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = val_i ? ST_PREP : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ax       <= '0;
            ay       <= '0;
            x_neg    <= 1'b0;
            y_neg    <= 1'b0;
            swap     <= 1'b0;
            zero_f   <= 1'b0;
            val_o    <= 1'b0;
            ratio_o  <= '0;
            octant_o <= '0;
        end else begin
            val_o <= (state == ST_DONE);
            if (accept) begin
                ax    <= ax_in;
                ay    <= ay_in;
                x_neg <= x_i[IN_W-1];
                y_neg <= y_i[IN_W-1];
            end
            if (state == ST_PREP) begin
                swap   <= swap_c;
                zero_f <= ((swap_c ? ay : ax) == '0);
            end
            // Capture on the DONE cycle; a sample accepted on the same edge only touches ax/ay/x_neg/y_neg
            if (state == ST_DONE) begin
                ratio_o  <= ratio_nxt;
                octant_o <= oct_nxt;
            end
        end
    end

endmodule
